banked_memory_bus: RTL and testbench

- Parametrised successor to the fixed four-bank CPU memory router.
- Decodes the top BANK_BITS address bits to one of 2^BANK_BITS banks.
- Adds a per-bank ready/wait-state handshake, so slow banks (SPI EEPROM, external RAM) can stall the CPU.
- Also adds a per-bank write-protect mask, a timeout with a bus-error report, and a registered read-data return.
- Sits between the CPU core and the ram, rom, peripherals and block_ram modules.

---
 rtl/banked_memory_bus_if.sv | 50 +++++
 rtl/banked_memory_bus.sv | 170 +++++++++++++++++
 tb/tb_banked_memory_bus.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/banked_memory_bus_if.sv
// -----------------------------------------------------------------------------
// banked_memory_bus_if
//   Bundles every signal between the CPU core, the bank router and the memory
//   banks (ram, rom, peripherals, block_ram).
//   Modports:
//     slave  - the router (banked_memory_bus): takes CPU requests and bank
//              replies, drives read data, status and bank strobes.
//     master - the environment (CPU core plus banks): drives the request and
//              the bank replies.
//   Signals:
//     address, data_in, bus_enable, write_enable   CPU request
//     data_out, ready, bus_error, error_address    CPU response / status
//     bank_address, bank_data_in                   latched request, all banks
//     bank_select, bank_write_enable               one-hot bank strobes
//     bank_data_out, bank_ready                    per-bank reply
// -----------------------------------------------------------------------------
interface banked_memory_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int BANK_BITS     = 2
);
  localparam int NUM_BANKS = 1 << BANK_BITS;

  logic [ADDRESS_WIDTH-1:0]           address;
  logic [DATA_WIDTH-1:0]              data_in;
  logic [DATA_WIDTH-1:0]              data_out;
  logic                               bus_enable;
  logic                               write_enable;
  logic                               ready;
  logic                               bus_error;
  logic [ADDRESS_WIDTH-1:0]           error_address;
  logic [ADDRESS_WIDTH-BANK_BITS-1:0] bank_address;
  logic [DATA_WIDTH-1:0]              bank_data_in;
  logic [NUM_BANKS*DATA_WIDTH-1:0]    bank_data_out;
  logic [NUM_BANKS-1:0]               bank_select;
  logic [NUM_BANKS-1:0]               bank_write_enable;
  logic [NUM_BANKS-1:0]               bank_ready;

  modport slave (
    input  address, data_in, bus_enable, write_enable, bank_data_out, bank_ready,
    output data_out, ready, bus_error, error_address,
           bank_address, bank_data_in, bank_select, bank_write_enable
  );

  modport master (
    output address, data_in, bus_enable, write_enable, bank_data_out, bank_ready,
    input  data_out, ready, bus_error, error_address,
           bank_address, bank_data_in, bank_select, bank_write_enable
  );
endinterface

// File: rtl/banked_memory_bus.sv
// -----------------------------------------------------------------------------
// banked_memory_bus
//   Routes CPU accesses to one of 2^BANK_BITS banks selected by the top
//   address bits. Each access is latched on acceptance, the bank may stall
//   with bank_ready, writes to write-protected banks are dropped silently, and
//   an access that stays unanswered for TIMEOUT cycles is aborted with a
//   bus-error report. Four-phase handshake: bus_enable up, ready up,
//   bus_enable down, ready down.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    slave view of banked_memory_bus_if (CPU and bank sides)
// -----------------------------------------------------------------------------
module banked_memory_bus #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int BANK_BITS     = 2,
  parameter int TIMEOUT       = 16,
  parameter logic [(1<<BANK_BITS)-1:0] WRITE_PROTECT = 4'b0010
) (
  input  logic                  clk,
  input  logic                  reset,
  banked_memory_bus_if.slave    bus
);
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int LOW_BITS  = ADDRESS_WIDTH - BANK_BITS;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;          // full latched address
  logic [LOW_BITS-1:0]     bank_address_q, bank_address_d;
  logic [DATA_WIDTH-1:0]   bank_data_in_q, bank_data_in_d;
  logic                    write_q, write_d;
  logic [BANK_BITS-1:0]    bank_q, bank_d;
  logic [NUM_BANKS-1:0]    bank_select_q, bank_select_d;
  logic [NUM_BANKS-1:0]    bank_write_enable_q, bank_write_enable_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    bus_error_q, bus_error_d;
  logic [ADDRESS_WIDTH-1:0] error_address_q, error_address_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [BANK_BITS-1:0]    req_bank;
  logic [NUM_BANKS-1:0]    req_onehot;

  assign req_bank   = bus.address[ADDRESS_WIDTH-1 -: BANK_BITS];
  assign req_onehot = NUM_BANKS'(1) << req_bank;

  always_comb begin
    // NOTE: every next-state value starts from its register so that no branch
    // leaves a signal unassigned (which would infer a latch).
    state_d             = state_q;
    addr_d              = addr_q;
    bank_address_d      = bank_address_q;
    bank_data_in_d      = bank_data_in_q;
    write_d             = write_q;
    bank_d              = bank_q;
    bank_select_d       = bank_select_q;
    bank_write_enable_d = bank_write_enable_q;
    data_out_d          = data_out_q;
    ready_d             = ready_q;
    bus_error_d         = bus_error_q;
    error_address_d     = error_address_q;
    count_d             = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.bus_enable) begin
          addr_d         = bus.address;
          bank_address_d = bus.address[LOW_BITS-1:0];
          bank_data_in_d = bus.data_in;
          write_d        = bus.write_enable;
          bank_d         = req_bank;
          if (bus.write_enable && WRITE_PROTECT[req_bank]) begin
            // Write to a read-only bank: complete at once, no strobe, no error.
            state_d     = ST_DONE;
            ready_d     = 1'b1;
            bus_error_d = 1'b0;
          end else begin
            state_d             = ST_ACCESS;
            bank_select_d       = req_onehot;
            bank_write_enable_d = bus.write_enable ? req_onehot : '0;
            count_d             = '0;
          end
        end
      end

      ST_ACCESS: begin
        if (bus.bank_ready[bank_q]) begin
          if (!write_q) begin
            data_out_d = bus.bank_data_out[int'(bank_q)*DATA_WIDTH +: DATA_WIDTH];
          end
          bank_select_d       = '0;
          bank_write_enable_d = '0;
          ready_d             = 1'b1;
          state_d             = ST_DONE;
        end else if (TIMEOUT != 0 && count_q == CNT_LAST) begin
          data_out_d          = '1;
          bus_error_d         = 1'b1;
          error_address_d     = addr_q;
          bank_select_d       = '0;
          bank_write_enable_d = '0;
          ready_d             = 1'b1;
          state_d             = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Hold ready (and any error) until the CPU withdraws its request;
        // a new request is only seen from IDLE, one cycle later.
        if (!bus.bus_enable) begin
          ready_d     = 1'b0;
          bus_error_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      addr_q              <= '0;
      bank_address_q      <= '0;
      bank_data_in_q      <= '0;
      write_q             <= 1'b0;
      bank_q              <= '0;
      bank_select_q       <= '0;
      bank_write_enable_q <= '0;
      data_out_q          <= '0;
      ready_q             <= 1'b0;
      bus_error_q         <= 1'b0;
      error_address_q     <= '0;
      count_q             <= '0;
    end else begin
      state_q             <= state_d;
      addr_q              <= addr_d;
      bank_address_q      <= bank_address_d;
      bank_data_in_q      <= bank_data_in_d;
      write_q             <= write_d;
      bank_q              <= bank_d;
      bank_select_q       <= bank_select_d;
      bank_write_enable_q <= bank_write_enable_d;
      data_out_q          <= data_out_d;
      ready_q             <= ready_d;
      bus_error_q         <= bus_error_d;
      error_address_q     <= error_address_d;
      count_q             <= count_d;
    end
  end

  assign bus.data_out          = data_out_q;
  assign bus.ready             = ready_q;
  assign bus.bus_error         = bus_error_q;
  assign bus.error_address     = error_address_q;
  assign bus.bank_address      = bank_address_q;
  assign bus.bank_data_in      = bank_data_in_q;
  assign bus.bank_select       = bank_select_q;
  assign bus.bank_write_enable = bank_write_enable_q;

endmodule

// File: tb/tb_banked_memory_bus.sv
// -----------------------------------------------------------------------------
// tb_banked_memory_bus
//   Directed bench for banked_memory_bus. Each transaction task derives the
//   whole expected timeline (strobe window, ready window, returned data, error
//   report) from the bank index, wait states, protection mask and timeout, and
//   a single compare process checks every DUT output against it on each
//   falling edge. Literal checks after each scenario pin the expected values.
// -----------------------------------------------------------------------------
module tb_banked_memory_bus;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BB = 2;
  localparam int TIMEOUT = 16;
  localparam logic [3:0]  WP = 4'b0010;
  localparam logic [63:0] BANK_DATA = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};

  logic clk = 1'b0;
  logic reset;

  banked_memory_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB)) bus ();

  banked_memory_bus #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB),
    .TIMEOUT(TIMEOUT), .WRITE_PROTECT(WP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.bank_data_out = BANK_DATA;

  // Expected outputs, updated just after each rising edge.
  logic [DW-1:0]    exp_dout;
  logic             exp_rdy;
  logic             exp_err;
  logic [AW-1:0]    exp_eaddr;
  logic [AW-BB-1:0] exp_baddr;
  logic [DW-1:0]    exp_bdin;
  logic [3:0]       exp_sel;
  logic [3:0]       exp_wen;
  bit               chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_exp();
    exp_dout  = '0; exp_rdy  = 1'b0; exp_err = 1'b0; exp_eaddr = '0;
    exp_baddr = '0; exp_bdin = '0;   exp_sel = '0;   exp_wen   = '0;
  endtask

  function automatic logic [DW-1:0] word_of(input int b);
    logic [63:0] all;
    all = BANK_DATA;
    return all[b*DW +: DW];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out",          bus.data_out,          exp_dout);
      check("ready",             bus.ready,             exp_rdy);
      check("bus_error",         bus.bus_error,         exp_err);
      check("error_address",     bus.error_address,     exp_eaddr);
      check("bank_address",      bus.bank_address,      exp_baddr);
      check("bank_data_in",      bus.bank_data_in,      exp_bdin);
      check("bank_select",       bus.bank_select,       exp_sel);
      check("bank_write_enable", bus.bank_write_enable, exp_wen);
      check("wen_not_protected", bus.bank_write_enable & WP, 4'b0000);
    end
  end

  // One CPU transaction. Interval 0 presents the request; it is accepted at
  // the next edge. waits = cycles the bank holds bank_ready low once
  // selected; hold = extra cycles the CPU keeps bus_enable high after ready.
  // The last interval has bus_enable low (DUT still in DONE).
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic we, input int waits, input int hold,
                         output int first_rdy, output int strobe_cnt, output int wen_cnt);
    int b, acc, r;
    logic [3:0] oh, rdy;
    bit prot, to;
    b    = int'(addr[AW-1 -: BB]);
    oh   = 4'b0001 << b;
    prot = we && WP[b];
    to   = !prot && (TIMEOUT != 0) && (waits >= TIMEOUT);
    acc  = prot ? 0 : (to ? TIMEOUT : waits + 1);   // cycles with strobes up
    r    = acc + 1;                                 // first ready interval
    first_rdy = -1; strobe_cnt = 0; wen_cnt = 0;
    for (int i = 0; i <= r + hold; i++) begin
      @(posedge clk); #1;
      bus.bus_enable = (i < r + hold);
      if (i == 0) begin
        bus.address = addr; bus.data_in = wdata; bus.write_enable = we;
      end else begin
        // Request lines change after acceptance; the DUT must ignore this.
        bus.address = addr ^ 16'hFFFF; bus.data_in = ~wdata; bus.write_enable = ~we;
      end
      rdy = 4'hF;
      if (!(waits == 0 || i > waits)) rdy[b] = 1'b0;
      bus.bank_ready = rdy;
      exp_sel = (i >= 1 && i <= acc) ? oh : 4'b0000;
      exp_wen = (we && !prot && i >= 1 && i <= acc) ? oh : 4'b0000;
      exp_rdy = (i >= r);
      exp_err = to && (i >= r);
      if (i == 1) begin exp_baddr = addr[AW-BB-1:0]; exp_bdin = wdata; end
      if (i == r) begin
        if (to) begin exp_dout = '1; exp_eaddr = addr; end
        else if (!we) exp_dout = word_of(b);
      end
      @(negedge clk);
      if (bus.ready === 1'b1 && first_rdy < 0) first_rdy = i;
      if (bus.bank_select != 4'b0000) strobe_cnt++;
      if (bus.bank_write_enable != 4'b0000) wen_cnt++;
    end
  endtask

  initial begin
    int fr, sc, wc;
    reset = 1'b1;
    bus.bus_enable = 1'b0; bus.address = '0; bus.data_in = '0;
    bus.write_enable = 1'b0; bus.bank_ready = 4'hF;
    clear_exp();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    // Zero-wait read of bank 1.
    run_txn(16'h4005, 16'h0000, 1'b0, 0, 2, fr, sc, wc);
    check("t2 first ready cycle", fr, 2);
    check("t2 strobe cycles", sc, 1);
    check("t2 data_out", bus.data_out, 16'hBEEF);
    check("t2 bank_address", bus.bank_address, 14'h0005);

    // Write to bank 3 with three wait states.
    run_txn(16'hC010, 16'h1234, 1'b1, 3, 1, fr, sc, wc);
    check("t3 write strobe cycles", wc, 4);
    check("t3 first ready cycle", fr, 5);
    check("t3 bank_data_in", bus.bank_data_in, 16'h1234);
    check("t3 data_out kept", bus.data_out, 16'hBEEF);

    // Write to protected bank 1.
    run_txn(16'h4000, 16'h5555, 1'b1, 0, 1, fr, sc, wc);
    check("t4 strobe cycles", sc, 0);
    check("t4 first ready cycle", fr, 1);
    check("t4 bus_error", bus.bus_error, 1'b0);

    // Read of bank 2 that never answers: timeout.
    run_txn(16'h8003, 16'h0000, 1'b0, 1000, 1, fr, sc, wc);
    check("t5 strobe cycles", sc, 16);
    check("t5 first ready cycle", fr, 17);
    check("t5 bus_error", bus.bus_error, 1'b1);
    check("t5 data_out", bus.data_out, 16'hFFFF);
    check("t5 error_address", bus.error_address, 16'h8003);

    // One wait state short of the timeout: completes normally.
    run_txn(16'hC001, 16'h0000, 1'b0, 15, 0, fr, sc, wc);
    check("edge first ready cycle", fr, 17);
    check("edge data_out", bus.data_out, 16'h3333);
    check("edge bus_error", bus.bus_error, 1'b0);

    // Back-to-back reads, bank 0 then bank 2, bus_enable held past completion.
    run_txn(16'h0007, 16'h0000, 1'b0, 1, 3, fr, sc, wc);
    check("t6a first ready cycle", fr, 3);
    check("t6a strobe cycles", sc, 2);
    run_txn(16'h8001, 16'h0000, 1'b0, 0, 1, fr, sc, wc);
    check("t6b first ready cycle", fr, 2);
    check("t6b data_out", bus.data_out, 16'h2222);
    check("t6b error_address sticky", bus.error_address, 16'h8003);

    // Reset in the middle of an access to bank 0.
    @(posedge clk); #1;
    bus.bus_enable = 1'b1; bus.address = 16'h0002; bus.data_in = 16'hAAAA;
    bus.write_enable = 1'b0; bus.bank_ready = 4'b1110;
    exp_sel = '0; exp_wen = '0; exp_rdy = 1'b0; exp_err = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      exp_sel = 4'b0001; exp_baddr = 14'h0002; exp_bdin = 16'hAAAA;
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.bus_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_exp();
    @(negedge clk);
    check("t1 bank_select after reset", bus.bank_select, 4'b0000);
    check("t1 data_out after reset", bus.data_out, 16'h0000);
    check("t1 error_address after reset", bus.error_address, 16'h0000);
    run_txn(16'h4005, 16'h0000, 1'b0, 0, 0, fr, sc, wc);
    check("t1 next first ready cycle", fr, 2);
    check("t1 next data_out", bus.data_out, 16'hBEEF);

    @(posedge clk); #1;
    exp_rdy = 1'b0; exp_err = 1'b0; exp_sel = '0; exp_wen = '0;
    @(negedge clk);
    @(posedge clk); #1 chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
